// File: rtl/scan_decoder_pkg.sv
// Shared definitions for the scan decoder: FSM state encoding and mode constants.
package scan_decoder_pkg;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StDirect = 2'd1,
    StScan   = 2'd2
  } state_e;

  localparam logic MODE_DIRECT = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;

endpackage

// File: rtl/onehot_dec.sv
// Combinational binary-to-one-hot decoder.
// Ports:
//   code_i   - SEL_W-bit select code
//   onehot_o - 2**SEL_W-bit one-hot vector, bit code_i set
// The top code bit enables either the upper or the lower half, each half being a decode of
// the remaining lower bits.
module onehot_dec #(
  parameter int unsigned SEL_W = 3,
  localparam int unsigned OUT_W = 2 ** SEL_W
) (
  input  logic [SEL_W-1:0] code_i,
  output logic [OUT_W-1:0] onehot_o
);

  if (SEL_W == 1) begin : g_leaf
    assign onehot_o = {code_i[0], ~code_i[0]};
  end else begin : g_split
    localparam int unsigned HalfW = OUT_W / 2;

    logic [HalfW-1:0] lower;
    assign lower = HalfW'(1) << code_i[SEL_W-2:0];

    assign onehot_o = {lower & {HalfW{code_i[SEL_W-1]}},
                       lower & {HalfW{~code_i[SEL_W-1]}}};
  end

endmodule

// File: rtl/scan_decoder.sv
// One-hot output driver with two modes: DIRECT decodes a supplied code, SCAN walks the active
// bit through all outputs, advancing one index every PERIOD clocks.
// Ports:
//   clk_i, rst_ni - clock, asynchronous active-low reset
//   en_i          - block enable; low returns to idle with all outputs cleared
//   mode_i        - 0 direct, 1 scan
//   in_valid_i    - in_sel_i carries a code (direct mode)
//   in_sel_i      - code to decode
//   in_ready_o    - code accepted this cycle when in_valid_i is high
//   dec_out_o     - registered one-hot output, or zero when inactive
//   cur_sel_o     - index of the active dec_out_o bit
//   wrap_o        - one-cycle pulse on the first cycle after the scan index wraps to 0
module scan_decoder
  import scan_decoder_pkg::*;
#(
  parameter int unsigned SEL_W  = 3,
  parameter int unsigned PERIOD = 4,
  localparam int unsigned OUT_W = 2 ** SEL_W
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             en_i,
  input  logic             mode_i,
  input  logic             in_valid_i,
  input  logic [SEL_W-1:0] in_sel_i,
  output logic             in_ready_o,
  output logic [OUT_W-1:0] dec_out_o,
  output logic [SEL_W-1:0] cur_sel_o,
  output logic             wrap_o
);

  localparam int unsigned DivW = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam logic [DivW-1:0] DivMax = DivW'(PERIOD - 1);
  localparam logic [SEL_W-1:0] SelMax = {SEL_W{1'b1}};

  state_e           state_q, state_d;
  logic [DivW-1:0]  div_q, div_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic [OUT_W-1:0] dec_q, dec_d;
  logic             wrap_q, wrap_d;
  logic             dec_load, dec_clear;
  logic [OUT_W-1:0] dec_next;

  always_comb begin
    state_d    = state_q;
    div_d      = '0;
    sel_d      = sel_q;
    wrap_d     = 1'b0;
    dec_load   = 1'b0;
    dec_clear  = 1'b0;
    in_ready_o = en_i & (mode_i == MODE_DIRECT);

    if (!en_i) begin
      state_d   = StIdle;
      sel_d     = '0;
      dec_clear = 1'b1;
    end else if (mode_i == MODE_SCAN) begin
      state_d  = StScan;
      dec_load = 1'b1;
      if (state_q != StScan) begin
        // Fresh scan always starts at index 0 with a cleared divider.
        sel_d = '0;
      end else if (div_q == DivMax) begin
        sel_d  = sel_q + SEL_W'(1);
        wrap_d = (sel_q == SelMax);
      end else begin
        div_d = div_q + DivW'(1);
      end
    end else begin
      // Direct: hold the previous output (zero from idle, last index from scan) until a code
      // is accepted.
      state_d = StDirect;
      if (in_valid_i) begin
        sel_d    = in_sel_i;
        dec_load = 1'b1;
      end
    end
  end

  onehot_dec #(
    .SEL_W(SEL_W)
  ) u_onehot_dec (
    .code_i  (sel_d),
    .onehot_o(dec_next)
  );

  always_comb begin
    dec_d = dec_q;
    if (dec_clear) begin
      dec_d = '0;
    end else if (dec_load) begin
      dec_d = dec_next;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      div_q   <= '0;
      sel_q   <= '0;
      dec_q   <= '0;
      wrap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      sel_q   <= sel_d;
      dec_q   <= dec_d;
      wrap_q  <= wrap_d;
    end
  end

  assign dec_out_o = dec_q;
  assign cur_sel_o = sel_q;
  assign wrap_o    = wrap_q;

endmodule
